// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide controller.
package mdu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned PROD_W     = 64;
  localparam int unsigned DIV_CYCLES = 34;
  localparam int unsigned DIV_ITERS  = 32;
  localparam int unsigned CNT_W      = 6;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  // Two's-complement negate of a data word (wraps for 0x80000000).
  function automatic logic [DATA_W-1:0] neg_word(input logic [DATA_W-1:0] x);
    return ~x + DATA_W'(1);
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_iter.sv
// Radix-2 restoring unsigned divider core: one quotient bit per enabled step.
module div_iter
  import mdu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              step_i,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W:0]   shifted_c;
  logic [DATA_W:0]   diff_c;

  // Load on start, otherwise shift in one dividend bit and trial-subtract.
  always_comb begin
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    shifted_c = {rem_q, quo_q[DATA_W-1]};
    diff_c    = shifted_c - {1'b0, dvs_q};
    if (start_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
    end else if (step_i) begin
      // Borrow out of bit DATA_W means the partial remainder was smaller.
      if (!diff_c[DATA_W]) begin
        rem_d = diff_c[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d = shifted_c[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Core registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// EXE-stage multiply/divide controller owning architectural HI/LO.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              EXE_Valid,
  input  mdu_op_t           EXE_MDUOp,
  input  logic [DATA_W-1:0] EXE_ResultA,
  input  logic [DATA_W-1:0] EXE_ResultB,
  input  logic              EXE_Advance,
  input  logic              EXE_Flush,
  output logic              EXE_MDUBusy,
  output logic [DATA_W-1:0] EXE_HI,
  output logic [DATA_W-1:0] EXE_LO
);

  mdu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_mul_q, is_mul_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              bzero_q, bzero_d;
  logic [DATA_W-1:0] a_raw_q, a_raw_d;
  logic [DATA_W-1:0] div_hi_q, div_hi_d;
  logic [DATA_W-1:0] div_lo_q, div_lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [PROD_W-1:0] mul_pipe_q [MUL_LAT];
  logic [PROD_W-1:0] mul_pipe_d [MUL_LAT];

  logic              is_md_op_c, is_mul_op_c, is_signed_c, accept_c;
  logic [PROD_W-1:0] a_ext_c, b_ext_c, prod_c;
  logic [DATA_W-1:0] a_abs_c, b_abs_c;
  logic              div_start_c, div_step_c, div_fix_c;
  logic [DATA_W-1:0] div_quo, div_rem, quo_fix_c, rem_fix_c;
  logic [PROD_W-1:0] res_c;

  // Operation decode and accept condition.
  always_comb begin
    is_md_op_c  = (EXE_MDUOp == MDU_MULT) || (EXE_MDUOp == MDU_MULTU) ||
                  (EXE_MDUOp == MDU_DIV)  || (EXE_MDUOp == MDU_DIVU);
    is_mul_op_c = (EXE_MDUOp == MDU_MULT) || (EXE_MDUOp == MDU_MULTU);
    is_signed_c = (EXE_MDUOp == MDU_MULT) || (EXE_MDUOp == MDU_DIV);
    accept_c    = EXE_Valid && (state_q == ST_IDLE) && !EXE_Flush && is_md_op_c;
  end

  // Stall request is combinational so the accept cycle itself stalls.
  assign EXE_MDUBusy = accept_c || (state_q == ST_MUL) || (state_q == ST_DIV);

  // Operand conditioning: extended operands for the product, magnitudes for divide.
  always_comb begin
    a_ext_c = {{DATA_W{is_signed_c & EXE_ResultA[DATA_W-1]}}, EXE_ResultA};
    b_ext_c = {{DATA_W{is_signed_c & EXE_ResultB[DATA_W-1]}}, EXE_ResultB};
    prod_c  = a_ext_c * b_ext_c;
    a_abs_c = (is_signed_c && EXE_ResultA[DATA_W-1]) ? neg_word(EXE_ResultA) : EXE_ResultA;
    b_abs_c = (is_signed_c && EXE_ResultB[DATA_W-1]) ? neg_word(EXE_ResultB) : EXE_ResultB;
  end

  // Divider sequencing: load on accept, 32 steps, then a sign-fixup cycle.
  always_comb begin
    div_start_c = accept_c && !is_mul_op_c;
    div_step_c  = (state_q == ST_DIV) && (cnt_q <= CNT_W'(DIV_ITERS));
    div_fix_c   = (state_q == ST_DIV) && (cnt_q == CNT_W'(DIV_CYCLES - 1));
  end

  div_iter u_div_iter (
    .clk         (clk),
    .rst_n       (resetn),
    .start_i     (div_start_c),
    .dividend_i  (a_abs_c),
    .divisor_i   (b_abs_c),
    .step_i      (div_step_c),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // FSM next state and cycle counter; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          cnt_d = CNT_W'(1);
          if (!is_mul_op_c)      state_d = ST_DIV;
          else if (MUL_LAT == 1) state_d = ST_DONE;
          else                   state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_LAT - 1)) state_d = ST_DONE;
      end
      ST_DIV: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_fix_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (EXE_Advance) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (EXE_Flush) state_d = ST_IDLE;
  end

  // Operand/sign latches, multiply delay line and divide result capture.
  always_comb begin
    is_mul_d  = is_mul_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    a_raw_d   = a_raw_q;
    div_hi_d  = div_hi_q;
    div_lo_d  = div_lo_q;
    for (int i = 0; i < MUL_LAT; i++) mul_pipe_d[i] = mul_pipe_q[i];
    for (int i = 1; i < MUL_LAT; i++) mul_pipe_d[i] = mul_pipe_q[i-1];

    if (accept_c) begin
      is_mul_d  = is_mul_op_c;
      neg_quo_d = is_signed_c & (EXE_ResultA[DATA_W-1] ^ EXE_ResultB[DATA_W-1]);
      neg_rem_d = is_signed_c & EXE_ResultA[DATA_W-1];
      bzero_d   = (EXE_ResultB == '0);
      a_raw_d   = EXE_ResultA;
      if (is_mul_op_c) mul_pipe_d[0] = prod_c;
    end

    quo_fix_c = neg_quo_q ? neg_word(div_quo) : div_quo;
    rem_fix_c = neg_rem_q ? neg_word(div_rem) : div_rem;
    if (div_fix_c) begin
      if (bzero_q) begin
        div_hi_d = a_raw_q;
        div_lo_d = '1;
      end else begin
        div_hi_d = rem_fix_c;
        div_lo_d = quo_fix_c;
      end
    end
  end

  // Architectural HI/LO: commit on unflushed DONE exit, or MTHI/MTLO from IDLE.
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    res_c = is_mul_q ? mul_pipe_q[MUL_LAT-1] : {div_hi_q, div_lo_q};
    if ((state_q == ST_DONE) && EXE_Advance && !EXE_Flush) begin
      hi_d = res_c[PROD_W-1:DATA_W];
      lo_d = res_c[DATA_W-1:0];
    end else if ((state_q == ST_IDLE) && EXE_Valid && EXE_Advance && !EXE_Flush) begin
      if (EXE_MDUOp == MDU_MTHI) hi_d = EXE_ResultA;
      if (EXE_MDUOp == MDU_MTLO) lo_d = EXE_ResultA;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_mul_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      a_raw_q   <= '0;
      div_hi_q  <= '0;
      div_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_mul_q  <= is_mul_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      a_raw_q   <= a_raw_d;
      div_hi_q  <= div_hi_d;
      div_lo_q  <= div_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Multiply delay line registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MUL_LAT; i++) mul_pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < MUL_LAT; i++) mul_pipe_q[i] <= mul_pipe_d[i];
    end
  end

  assign EXE_HI = hi_q;
  assign EXE_LO = lo_q;

endmodule
